// File: rtl/vnet_rr_vc_allocator_if.sv
// Bundle of the request/grant/availability signals exchanged between the
// input blocks and the VC allocator.
//   master : upstream side, drives requests, target port/VNET and idle flags
//   slave  : allocator side, returns grants, allocated VC and availability
// Per-VC fields are packed flat with upstream VC [p][v] at index p*VC_NUM+v.
interface vnet_rr_vc_allocator_if #(
  parameter int PORT_NUM = 5,
  parameter int VC_NUM   = 4,
  parameter int VNET_NUM = 2
);
  localparam int VC_SIZE   = $clog2(VC_NUM);
  localparam int PORT_SIZE = $clog2(PORT_NUM);
  localparam int VNET_SIZE = (VNET_NUM > 1) ? $clog2(VNET_NUM) : 1;

  logic [PORT_NUM*VC_NUM-1:0]           vc_request_i;
  logic [PORT_NUM*VC_NUM*PORT_SIZE-1:0] out_port_i;
  logic [PORT_NUM*VC_NUM*VNET_SIZE-1:0] vnet_i;
  logic [PORT_NUM*VC_NUM-1:0]           idle_downstream_vc_i;
  logic [PORT_NUM*VC_NUM-1:0]           vc_valid_o;
  logic [PORT_NUM*VC_NUM*VC_SIZE-1:0]   vc_new_o;
  logic [PORT_NUM*VC_NUM-1:0]           available_vc_o;

  modport master (
    output vc_request_i, out_port_i, vnet_i, idle_downstream_vc_i,
    input  vc_valid_o, vc_new_o, available_vc_o
  );

  modport slave (
    input  vc_request_i, out_port_i, vnet_i, idle_downstream_vc_i,
    output vc_valid_o, vc_new_o, available_vc_o
  );
endinterface

// File: rtl/vnet_rr_vc_allocator.sv
// Router-level virtual-channel allocator. Each requesting upstream VC is
// given a free downstream VC inside its own virtual network on the target
// port. Separable input-first allocation: a round-robin arbiter per upstream
// port, then a round-robin arbiter per (downstream port, VNET). The
// downstream VC itself is picked round-robin inside the VNET slice.
// Ports:
//   clk      : clock
//   rst      : asynchronous active-high reset
//   alloc_if : slave side of vnet_rr_vc_allocator_if (requests, target
//              port/VNET, idle flags in; grants, allocated VC, availability out)
module vnet_rr_vc_allocator #(
  parameter int PORT_NUM = 5,
  parameter int VC_NUM   = 4,
  parameter int VNET_NUM = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  vnet_rr_vc_allocator_if.slave  alloc_if
);
  localparam int VPV       = VC_NUM / VNET_NUM;
  localparam int VC_SIZE   = $clog2(VC_NUM);
  localparam int PORT_SIZE = $clog2(PORT_NUM);
  localparam int VNET_SIZE = (VNET_NUM > 1) ? $clog2(VNET_NUM) : 1;
  localparam int OFF_SIZE  = (VPV > 1) ? $clog2(VPV) : 1;

  function automatic logic [VC_SIZE-1:0] nextVc(input logic [VC_SIZE-1:0] x);
    return (x == VC_SIZE'(VC_NUM - 1)) ? '0 : x + 1'b1;
  endfunction

  function automatic logic [PORT_SIZE-1:0] nextPort(input logic [PORT_SIZE-1:0] x);
    return (x == PORT_SIZE'(PORT_NUM - 1)) ? '0 : x + 1'b1;
  endfunction

  function automatic logic [OFF_SIZE-1:0] nextOff(input logic [OFF_SIZE-1:0] x);
    return (x == OFF_SIZE'(VPV - 1)) ? '0 : x + 1'b1;
  endfunction

  logic [PORT_NUM-1:0][VC_NUM-1:0]                 avail_q, avail_d;
  logic [PORT_NUM-1:0][VC_SIZE-1:0]                inPtr_q, inPtr_d;
  logic [PORT_NUM-1:0][VNET_NUM-1:0][PORT_SIZE-1:0] outPtr_q, outPtr_d;
  logic [PORT_NUM-1:0][VNET_NUM-1:0][OFF_SIZE-1:0]  vcPtr_q, vcPtr_d;

  logic [PORT_NUM-1:0][VC_NUM-1:0]                 request;
  logic [PORT_NUM-1:0][VC_NUM-1:0][PORT_SIZE-1:0]  reqPort;
  logic [PORT_NUM-1:0][VC_NUM-1:0][VNET_SIZE-1:0]  reqVnet;
  logic [PORT_NUM-1:0][VC_NUM-1:0]                 idleVc;

  logic [PORT_NUM-1:0][VNET_NUM-1:0]               anyFree;
  logic [PORT_NUM-1:0][VC_NUM-1:0]                 eligible;
  logic [PORT_NUM-1:0]                             s1Valid;
  logic [PORT_NUM-1:0][VC_SIZE-1:0]                s1Vc;
  logic [PORT_NUM-1:0][PORT_SIZE-1:0]              s1Port;
  logic [PORT_NUM-1:0][VNET_SIZE-1:0]              s1Vnet;

  logic [PORT_NUM-1:0][VC_NUM-1:0]                 grantValid;
  logic [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0]    grantVc;

  assign request = alloc_if.vc_request_i;
  assign reqPort = alloc_if.out_port_i;
  assign reqVnet = alloc_if.vnet_i;
  assign idleVc  = alloc_if.idle_downstream_vc_i;

  // Eligibility and input-stage arbitration. Matching the target against
  // every legal (port, VNET) pair means out-of-range targets never qualify.
  always_comb begin
    logic [VC_SIZE-1:0] vcIdx;
    vcIdx    = '0;
    anyFree  = '0;
    eligible = '0;
    s1Valid  = '0;
    s1Vc     = '0;
    s1Port   = '0;
    s1Vnet   = '0;
    for (int d = 0; d < PORT_NUM; d++) begin
      for (int n = 0; n < VNET_NUM; n++) begin
        anyFree[d][n] = |avail_q[d][n*VPV +: VPV];
      end
    end
    for (int p = 0; p < PORT_NUM; p++) begin
      for (int v = 0; v < VC_NUM; v++) begin
        for (int d = 0; d < PORT_NUM; d++) begin
          for (int n = 0; n < VNET_NUM; n++) begin
            if (request[p][v] && reqPort[p][v] == PORT_SIZE'(d) &&
                reqVnet[p][v] == VNET_SIZE'(n) && anyFree[d][n]) begin
              eligible[p][v] = 1'b1;
            end
          end
        end
      end
    end
    for (int p = 0; p < PORT_NUM; p++) begin
      vcIdx = inPtr_q[p];
      for (int i = 0; i < VC_NUM; i++) begin
        if (!s1Valid[p] && eligible[p][vcIdx]) begin
          s1Valid[p] = 1'b1;
          s1Vc[p]    = vcIdx;
        end
        vcIdx = nextVc(vcIdx);
      end
      s1Port[p] = reqPort[p][s1Vc[p]];
      s1Vnet[p] = reqVnet[p][s1Vc[p]];
    end
  end

  // Output-stage arbitration, downstream VC choice and next-state update.
  // A stage-1 winner always has a free VC in its slice, so a stage-2 winner
  // always finds one. Releases are ORed in; idle on a free VC is a no-op.
  always_comb begin
    logic [PORT_SIZE-1:0] pIdx;
    logic [PORT_SIZE-1:0] winP;
    logic                 found;
    logic [OFF_SIZE-1:0]  off;
    logic [OFF_SIZE-1:0]  winOff;
    logic                 vcFound;
    logic [VPV-1:0]       slice;
    logic [VC_SIZE-1:0]   winK;
    pIdx       = '0;
    winP       = '0;
    found      = 1'b0;
    off        = '0;
    winOff     = '0;
    vcFound    = 1'b0;
    slice      = '0;
    winK       = '0;
    avail_d    = avail_q | idleVc;
    inPtr_d    = inPtr_q;
    outPtr_d   = outPtr_q;
    vcPtr_d    = vcPtr_q;
    grantValid = '0;
    grantVc    = '0;
    for (int d = 0; d < PORT_NUM; d++) begin
      for (int n = 0; n < VNET_NUM; n++) begin
        found = 1'b0;
        winP  = '0;
        pIdx  = outPtr_q[d][n];
        for (int i = 0; i < PORT_NUM; i++) begin
          if (!found && s1Valid[pIdx] && s1Port[pIdx] == PORT_SIZE'(d) &&
              s1Vnet[pIdx] == VNET_SIZE'(n)) begin
            found = 1'b1;
            winP  = pIdx;
          end
          pIdx = nextPort(pIdx);
        end
        vcFound = 1'b0;
        winOff  = '0;
        slice   = avail_q[d][n*VPV +: VPV];
        off     = vcPtr_q[d][n];
        for (int j = 0; j < VPV; j++) begin
          if (!vcFound && slice[off]) begin
            vcFound = 1'b1;
            winOff  = off;
          end
          off = nextOff(off);
        end
        winK = VC_SIZE'(n*VPV) + VC_SIZE'(winOff);
        if (found && vcFound) begin
          grantValid[winP][s1Vc[winP]] = 1'b1;
          grantVc[winP][s1Vc[winP]]    = winK;
          avail_d[d][winK]             = 1'b0;
          inPtr_d[winP]                = nextVc(s1Vc[winP]);
          outPtr_d[d][n]               = nextPort(winP);
          vcPtr_d[d][n]                = nextOff(winOff);
        end
      end
    end
  end

  // Grants are suppressed during reset so nothing is issued against state
  // that is being cleared.
  assign alloc_if.vc_valid_o     = rst ? '0 : grantValid;
  assign alloc_if.vc_new_o       = rst ? '0 : grantVc;
  assign alloc_if.available_vc_o = avail_q;

  // Allocator state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      avail_q  <= '1;
      inPtr_q  <= '0;
      outPtr_q <= '0;
      vcPtr_q  <= '0;
    end else begin
      avail_q  <= avail_d;
      inPtr_q  <= inPtr_d;
      outPtr_q <= outPtr_d;
      vcPtr_q  <= vcPtr_d;
    end
  end
endmodule

// File: tb/tb_vnet_rr_vc_allocator.sv
// Directed testbench for vnet_rr_vc_allocator (5 ports, 4 VCs, 2 VNETs).
// Inputs change on the falling edge; combinational grants are sampled 2ns
// later, well before the next rising edge.
module tb_vnet_rr_vc_allocator;
  localparam int PN = 5;
  localparam int VN = 4;
  localparam int NN = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   testCount = 0;
  int   failCount = 0;

  vnet_rr_vc_allocator_if #(.PORT_NUM(PN), .VC_NUM(VN), .VNET_NUM(NN)) allocIf();

  vnet_rr_vc_allocator #(.PORT_NUM(PN), .VC_NUM(VN), .VNET_NUM(NN)) dut (
    .clk      (clk),
    .rst      (rst),
    .alloc_if (allocIf.slave)
  );

  always #5 clk = ~clk;

  // Clear every upstream-driven input.
  task automatic clearInputs();
    allocIf.vc_request_i         = '0;
    allocIf.out_port_i           = '0;
    allocIf.vnet_i               = '0;
    allocIf.idle_downstream_vc_i = '0;
  endtask

  // Raise the request of upstream VC [p][v] towards (port, vnet).
  task automatic setReq(input int p, input int v, input int port, input int vnet);
    allocIf.vc_request_i[p*VN+v]      = 1'b1;
    allocIf.out_port_i[(p*VN+v)*3 +: 3] = 3'(port);
    allocIf.vnet_i[p*VN+v]            = 1'(vnet);
  endtask

  task automatic dropReq(input int p, input int v);
    allocIf.vc_request_i[p*VN+v] = 1'b0;
  endtask

  // Pulse reset for one cycle; returns on a falling edge with rst low.
  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    clearInputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clearInputs();
    setReq(0, 0, 2, 0);
    @(negedge clk); #2;
    testCount++; if (allocIf.vc_valid_o !== 20'h00000) begin failCount++; $display("[TB] FAIL reset_valid: got %h expected %h", allocIf.vc_valid_o, 20'h00000); end
    testCount++; if (allocIf.vc_new_o !== 40'h0) begin failCount++; $display("[TB] FAIL reset_new: got %h expected %h", allocIf.vc_new_o, 40'h0); end
    testCount++; if (allocIf.available_vc_o !== 20'hFFFFF) begin failCount++; $display("[TB] FAIL reset_avail: got %h expected %h", allocIf.available_vc_o, 20'hFFFFF); end
    @(negedge clk);
    rst = 1'b0;
    clearInputs();
    @(negedge clk); #2;
    testCount++; if (allocIf.available_vc_o !== 20'hFFFFF) begin failCount++; $display("[TB] FAIL idle_avail: got %h expected %h", allocIf.available_vc_o, 20'hFFFFF); end
    testCount++; if (allocIf.vc_valid_o !== 20'h00000) begin failCount++; $display("[TB] FAIL idle_valid: got %h expected %h", allocIf.vc_valid_o, 20'h00000); end
  endtask

  task automatic test_basic_alloc();
    doReset();
    setReq(0, 0, 2, 0); #2;
    testCount++; if (allocIf.vc_valid_o !== 20'h00001) begin failCount++; $display("[TB] FAIL basic_g0_valid: got %h expected %h", allocIf.vc_valid_o, 20'h00001); end
    testCount++; if (allocIf.vc_new_o !== 40'h0) begin failCount++; $display("[TB] FAIL basic_g0_new: got %h expected %h", allocIf.vc_new_o, 40'h0); end
    @(negedge clk); dropReq(0, 0); setReq(1, 0, 2, 0); #2;
    testCount++; if (allocIf.available_vc_o !== 20'hFFEFF) begin failCount++; $display("[TB] FAIL basic_avail1: got %h expected %h", allocIf.available_vc_o, 20'hFFEFF); end
    testCount++; if (allocIf.vc_valid_o !== 20'h00010) begin failCount++; $display("[TB] FAIL basic_g1_valid: got %h expected %h", allocIf.vc_valid_o, 20'h00010); end
    testCount++; if (allocIf.vc_new_o !== 40'h100) begin failCount++; $display("[TB] FAIL basic_g1_new: got %h expected %h", allocIf.vc_new_o, 40'h100); end
    @(negedge clk); dropReq(1, 0); setReq(2, 0, 2, 0); #2;
    testCount++; if (allocIf.vc_valid_o !== 20'h00000) begin failCount++; $display("[TB] FAIL basic_vnet0_full: got %h expected %h", allocIf.vc_valid_o, 20'h00000); end
    testCount++; if (allocIf.available_vc_o !== 20'hFFCFF) begin failCount++; $display("[TB] FAIL basic_avail2: got %h expected %h", allocIf.available_vc_o, 20'hFFCFF); end
    @(negedge clk); dropReq(2, 0); setReq(3, 0, 2, 1); #2;
    testCount++; if (allocIf.vc_valid_o !== 20'h01000) begin failCount++; $display("[TB] FAIL basic_vnet1_valid: got %h expected %h", allocIf.vc_valid_o, 20'h01000); end
    testCount++; if (allocIf.vc_new_o !== 40'h0002000000) begin failCount++; $display("[TB] FAIL basic_vnet1_new: got %h expected %h", allocIf.vc_new_o, 40'h0002000000); end
    @(negedge clk); dropReq(3, 0); #2;
    testCount++; if (allocIf.available_vc_o !== 20'hFF8FF) begin failCount++; $display("[TB] FAIL basic_avail3: got %h expected %h", allocIf.available_vc_o, 20'hFF8FF); end
  endtask

  task automatic test_parallel_vnets();
    doReset();
    setReq(0, 0, 2, 0); setReq(1, 0, 2, 1); #2;
    testCount++; if (allocIf.vc_valid_o !== 20'h00011) begin failCount++; $display("[TB] FAIL par_valid: got %h expected %h", allocIf.vc_valid_o, 20'h00011); end
    testCount++; if (allocIf.vc_new_o !== 40'h200) begin failCount++; $display("[TB] FAIL par_new: got %h expected %h", allocIf.vc_new_o, 40'h200); end
    @(negedge clk); clearInputs(); #2;
    testCount++; if (allocIf.available_vc_o !== 20'hFFAFF) begin failCount++; $display("[TB] FAIL par_avail: got %h expected %h", allocIf.available_vc_o, 20'hFFAFF); end
  endtask

  task automatic test_output_contention();
    doReset();
    setReq(0, 0, 3, 0); setReq(1, 0, 3, 0); #2;
    testCount++; if (allocIf.vc_valid_o !== 20'h00001) begin failCount++; $display("[TB] FAIL outc_first_valid: got %h expected %h", allocIf.vc_valid_o, 20'h00001); end
    testCount++; if (allocIf.vc_new_o !== 40'h0) begin failCount++; $display("[TB] FAIL outc_first_new: got %h expected %h", allocIf.vc_new_o, 40'h0); end
    @(negedge clk); dropReq(0, 0); #2;
    testCount++; if (allocIf.vc_valid_o !== 20'h00010) begin failCount++; $display("[TB] FAIL outc_second_valid: got %h expected %h", allocIf.vc_valid_o, 20'h00010); end
    testCount++; if (allocIf.vc_new_o !== 40'h100) begin failCount++; $display("[TB] FAIL outc_second_new: got %h expected %h", allocIf.vc_new_o, 40'h100); end
    @(negedge clk); clearInputs(); #2;
    testCount++; if (allocIf.available_vc_o !== 20'hFCFFF) begin failCount++; $display("[TB] FAIL outc_avail: got %h expected %h", allocIf.available_vc_o, 20'hFCFFF); end
  endtask

  task automatic test_input_contention();
    logic [19:0] expValid [4];
    logic [39:0] expNew   [4];
    expValid = '{20'h00001, 20'h00002, 20'h00001, 20'h00002};
    expNew   = '{40'h0, 40'h0, 40'h1, 40'h4};
    doReset();
    setReq(0, 0, 1, 0); setReq(0, 1, 4, 0);
    for (int c = 0; c < 4; c++) begin
      #2;
      testCount++; if (allocIf.vc_valid_o !== expValid[c]) begin failCount++; $display("[TB] FAIL inc_valid_c%0d: got %h expected %h", c, allocIf.vc_valid_o, expValid[c]); end
      testCount++; if (allocIf.vc_new_o !== expNew[c]) begin failCount++; $display("[TB] FAIL inc_new_c%0d: got %h expected %h", c, allocIf.vc_new_o, expNew[c]); end
      @(negedge clk);
    end
    clearInputs(); #2;
    testCount++; if (allocIf.available_vc_o !== 20'hCFFCF) begin failCount++; $display("[TB] FAIL inc_avail: got %h expected %h", allocIf.available_vc_o, 20'hCFFCF); end
  endtask

  task automatic test_release();
    doReset();
    setReq(0, 0, 2, 0); #2;
    testCount++; if (allocIf.vc_valid_o !== 20'h00001) begin failCount++; $display("[TB] FAIL rel_fill0: got %h expected %h", allocIf.vc_valid_o, 20'h00001); end
    @(negedge clk); dropReq(0, 0); setReq(1, 0, 2, 0); #2;
    testCount++; if (allocIf.vc_valid_o !== 20'h00010) begin failCount++; $display("[TB] FAIL rel_fill1: got %h expected %h", allocIf.vc_valid_o, 20'h00010); end
    @(negedge clk); dropReq(1, 0); setReq(2, 0, 2, 0); allocIf.idle_downstream_vc_i[8] = 1'b1; #2;
    testCount++; if (allocIf.vc_valid_o !== 20'h00000) begin failCount++; $display("[TB] FAIL rel_no_bypass: got %h expected %h", allocIf.vc_valid_o, 20'h00000); end
    testCount++; if (allocIf.available_vc_o !== 20'hFFCFF) begin failCount++; $display("[TB] FAIL rel_avail_full: got %h expected %h", allocIf.available_vc_o, 20'hFFCFF); end
    @(negedge clk); allocIf.idle_downstream_vc_i[8] = 1'b0; #2;
    testCount++; if (allocIf.available_vc_o !== 20'hFFDFF) begin failCount++; $display("[TB] FAIL rel_avail_back: got %h expected %h", allocIf.available_vc_o, 20'hFFDFF); end
    testCount++; if (allocIf.vc_valid_o !== 20'h00100) begin failCount++; $display("[TB] FAIL rel_grant_valid: got %h expected %h", allocIf.vc_valid_o, 20'h00100); end
    testCount++; if (allocIf.vc_new_o !== 40'h0) begin failCount++; $display("[TB] FAIL rel_grant_new: got %h expected %h", allocIf.vc_new_o, 40'h0); end
    @(negedge clk); dropReq(2, 0); allocIf.idle_downstream_vc_i[0] = 1'b1; #2;
    testCount++; if (allocIf.available_vc_o !== 20'hFFCFF) begin failCount++; $display("[TB] FAIL rel_after_grant: got %h expected %h", allocIf.available_vc_o, 20'hFFCFF); end
    @(negedge clk); allocIf.idle_downstream_vc_i[0] = 1'b0; #2;
    testCount++; if (allocIf.available_vc_o !== 20'hFFCFF) begin failCount++; $display("[TB] FAIL rel_idle_free_ignored: got %h expected %h", allocIf.available_vc_o, 20'hFFCFF); end
  endtask

  task automatic test_vc_ptr_wrap();
    int expSeq [4];
    expSeq = '{0, 1, 0, 1};
    doReset();
    for (int r = 0; r < 4; r++) begin
      setReq(0, 0, 2, 0); #2;
      testCount++; if (allocIf.vc_valid_o !== 20'h00001) begin failCount++; $display("[TB] FAIL wrap_valid_r%0d: got %h expected %h", r, allocIf.vc_valid_o, 20'h00001); end
      testCount++; if (allocIf.vc_new_o !== 40'(expSeq[r])) begin failCount++; $display("[TB] FAIL wrap_new_r%0d: got %h expected %h", r, allocIf.vc_new_o, 40'(expSeq[r])); end
      @(negedge clk); dropReq(0, 0); allocIf.idle_downstream_vc_i[8+expSeq[r]] = 1'b1;
      @(negedge clk); allocIf.idle_downstream_vc_i = '0;
    end
    setReq(1, 0, 7, 0); setReq(2, 3, 5, 1); #2;
    testCount++; if (allocIf.vc_valid_o !== 20'h00000) begin failCount++; $display("[TB] FAIL oor_valid0: got %h expected %h", allocIf.vc_valid_o, 20'h00000); end
    @(negedge clk); #2;
    testCount++; if (allocIf.vc_valid_o !== 20'h00000) begin failCount++; $display("[TB] FAIL oor_valid1: got %h expected %h", allocIf.vc_valid_o, 20'h00000); end
    testCount++; if (allocIf.available_vc_o !== 20'hFFFFF) begin failCount++; $display("[TB] FAIL oor_avail: got %h expected %h", allocIf.available_vc_o, 20'hFFFFF); end
    clearInputs();
  endtask

  task automatic test_midrun_reset();
    doReset();
    setReq(0, 0, 2, 0); setReq(1, 1, 3, 1); #2;
    testCount++; if (allocIf.vc_valid_o !== 20'h00021) begin failCount++; $display("[TB] FAIL mid_valid: got %h expected %h", allocIf.vc_valid_o, 20'h00021); end
    testCount++; if (allocIf.vc_new_o !== 40'h800) begin failCount++; $display("[TB] FAIL mid_new: got %h expected %h", allocIf.vc_new_o, 40'h800); end
    @(negedge clk); clearInputs(); #2;
    testCount++; if (allocIf.available_vc_o !== 20'hFBEFF) begin failCount++; $display("[TB] FAIL mid_avail_pre: got %h expected %h", allocIf.available_vc_o, 20'hFBEFF); end
    setReq(0, 0, 2, 0);
    #1 rst = 1'b1;
    #1;
    testCount++; if (allocIf.available_vc_o !== 20'hFFFFF) begin failCount++; $display("[TB] FAIL mid_avail_async: got %h expected %h", allocIf.available_vc_o, 20'hFFFFF); end
    testCount++; if (allocIf.vc_valid_o !== 20'h00000) begin failCount++; $display("[TB] FAIL mid_valid_forced: got %h expected %h", allocIf.vc_valid_o, 20'h00000); end
    @(negedge clk);
    rst = 1'b0;
    clearInputs();
  endtask

  initial begin
    test_reset();
    test_basic_alloc();
    test_parallel_vnets();
    test_output_contention();
    test_input_contention();
    test_release();
    test_vc_ptr_wrap();
    test_midrun_reset();
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end
endmodule

// File: doc/vnet_rr_vc_allocator.md
Name: vnet_rr_vc_allocator

Overview:
Router-level virtual-channel allocator for the chiplet NoC router. It assigns a free downstream VC to each upstream input VC that requests one. Downstream VCs are partitioned into virtual networks (VNETs); allocation is confined to the requester's VNET. Downstream VC choice is round-robin per downstream port and VNET. Contention is resolved by a separable input-first allocator with round-robin arbiters on both stages. The block sits between the input blocks and the switch allocator.

Parameters:
PORT_NUM, 5, number of router ports (upstream = downstream count)
VC_NUM, 4, VCs per port; must be divisible by VNET_NUM
VNET_NUM, 2, number of virtual networks; VPV = VC_NUM/VNET_NUM VCs per VNET; VNET v owns VCs v*VPV .. v*VPV+VPV-1
Derived widths: VC_SIZE=$clog2(VC_NUM), PORT_SIZE=$clog2(PORT_NUM), VNET_SIZE=max(1,$clog2(VNET_NUM))

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
vc_request_i  in  PORT_NUM*VC_NUM  upstream VC [p][v] requests a downstream VC
out_port_i  in  PORT_NUM*VC_NUM*PORT_SIZE  target downstream port per upstream VC
vnet_i  in  PORT_NUM*VC_NUM*VNET_SIZE  VNET of the packet per upstream VC
idle_downstream_vc_i  in  PORT_NUM*VC_NUM  downstream VC [p][v] has drained and may be released
vc_valid_o  out  PORT_NUM*VC_NUM  grant to upstream VC [p][v] this cycle
vc_new_o  out  PORT_NUM*VC_NUM*VC_SIZE  allocated downstream VC index; 0 when not valid
available_vc_o  out  PORT_NUM*VC_NUM  registered availability state

Behaviour:
- State (all flops, async reset):
  - avail[PORT_NUM][VC_NUM], reset all 1.
  - in_ptr[PORT_NUM] (VC_SIZE), reset 0.
  - out_ptr[PORT_NUM][VNET_NUM] (PORT_SIZE), reset 0.
  - vc_ptr[PORT_NUM][VNET_NUM] (VC offset within VNET), reset 0.
- Eligibility: request [p][v] is eligible iff vc_request_i[p][v] is 1, out_port_i < PORT_NUM, vnet_i < VNET_NUM, and avail has at least one 1 within the target port's VNET slice. Requests with out-of-range port or VNET are never eligible.
- Stage 1 (input): per upstream port p, a round-robin arbiter selects one eligible VC. Search starts at in_ptr[p] and wraps.
- Stage 2 (output): per (downstream port d, VNET n), a round-robin arbiter selects one upstream port among stage-1 winners targeting (d,n). Search starts at out_ptr[d][n] and wraps.
- Downstream VC choice: the first avail VC in VNET n of port d, searching from offset vc_ptr[d][n] with wrap inside the VNET slice.
- Grant timing: vc_valid_o and vc_new_o are combinational, valid in the same cycle as the request. They are computed from registered state only. While rst is high they are forced to 0.
- At most one grant per upstream port per cycle, and at most one grant per (d,n) per cycle. Different VNETs of the same downstream port may be granted in the same cycle.
- Next-state update, on a grant to [p][v] for downstream VC k of (d,n):
  - avail[d][k] becomes 0.
  - in_ptr[p] becomes v+1 (mod VC_NUM).
  - out_ptr[d][n] becomes p+1 (mod PORT_NUM).
  - vc_ptr[d][n] becomes (k-n*VPV)+1 (mod VPV).
- Pointers of arbiters that issue no grant hold their value.
- Release: idle_downstream_vc_i[d][k] with avail[d][k]=0 sets avail[d][k]=1 on the next edge. Idle on an already-available VC is ignored.
- Allocate/release in the same cycle on the same VC cannot occur, because allocation requires avail=1 and release requires avail=0.
- Released VCs are not grantable until the cycle after release (no bypass).
- Upstream VCs must deassert vc_request_i after receiving vc_valid_o. A request held high is treated as a new request.
- Reset mid-operation: all state returns to reset values immediately and outputs drop to 0. Grants issued in that cycle are void.

Test Plan (PORT_NUM=5, VC_NUM=4, VNET_NUM=2):
1. Reset, then idle -> available_vc_o=20'hFFFFF, vc_valid_o=0. Assert rst mid-run after allocations -> available_vc_o returns to 20'hFFFFF asynchronously.
2. [0][0] requests port 2, VNET 0 -> same cycle vc_valid[0][0]=1, vc_new=0; next cycle avail[2][0]=0. [1][0] requests same -> vc_new=1. A third VNET 0 request to port 2 -> no grant. A VNET 1 request to port 2 -> vc_new=2.
3. [0][0] and [1][0] request port 3, VNET 0 in the same cycle -> only [0][0] granted (VC0). [1][0] holds its request and is granted VC1 the next cycle.
4. [0][0] requests port 1 and [0][1] requests port 4 in the same cycle -> only [0][0] granted. Next cycle [0][1] granted. Then with both requesting again, the grant alternates between them.
5. Port 2 VNET 0 full; assert idle[2][0] together with a new request -> no grant that cycle; next cycle avail[2][0]=1 and the request is granted vc_new=0. Assert idle on an available VC -> no state change.
6. Requests to port 2 VNET 0 with releases in between -> vc_new sequence 0,1,0,1 (vc_ptr wraps within the VNET slice). out_port_i=7 -> never granted.
